// File: rtl/neuron_spike_out_bank.sv
// -----------------------------------------------------------------------------
// neuron_spike_out_bank
//   Multi-word spike output buffer. The neuron core deposits 32-bit spike
//   packets by word index. Each word has a "fresh" flag that is set on every
//   external deposit. The host reads the words, reads the fresh mask through
//   STATUS, and clears flags over a Wishbone slave port.
//
//   Handshake: a request is cyc & stb & ~ack. The ack follows one cycle after
//   the request and is one cycle wide, so a held strobe is acked on every
//   other cycle. Read data and all bus side effects are taken in the request
//   cycle. Read data is the value before any same-cycle update.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]              byte lanes (writes only)
//   wbs_adr_i[31:0]             byte address
//   wbs_dat_i[31:0]             write data
//   wbs_ack_o                   single-cycle acknowledge
//   wbs_dat_o[31:0]             read data, held until the next ack
//   external_spike_data_i[31:0] spike word from the neuron core
//   external_write_en_i         external write strobe
//   external_word_idx_i         external target word index
//   spike_pending_o             fresh-flag mask
//   spike_irq_o                 registered OR of the fresh mask
//
// Address map (word offset from BASE_ADDR)
//   0..NUM_WORDS-1  spike data words
//   NUM_WORDS       STATUS: read = fresh mask, write 1 = clear flag
//   others          read 0, writes ignored, always acked
// -----------------------------------------------------------------------------
module neuron_spike_out_bank #(
   parameter logic [31:0] BASE_ADDR     = 32'h3000_8000,
   parameter int          NUM_WORDS     = 8,
   parameter int          IDX_W         = 3,
   parameter int          ACCUMULATE    = 0,
   parameter int          CLEAR_ON_READ = 0
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic                 wbs_ack_o,
   output logic [31:0]          wbs_dat_o,
   input  logic [31:0]          external_spike_data_i,
   input  logic                 external_write_en_i,
   input  logic [IDX_W-1:0]     external_word_idx_i,
   output logic [NUM_WORDS-1:0] spike_pending_o,
   output logic                 spike_irq_o
);

   logic [31:0]          r_word [NUM_WORDS];
   logic [NUM_WORDS-1:0] r_fresh;
   logic                 r_ack;
   logic [31:0]          r_dat;
   logic                 r_irq;

   logic        w_req;
   logic [31:0] w_off;
   logic        w_is_stat;
   logic [31:0] w_sel_mask;
   logic [31:0] w_ext_idx;
   logic        w_ext_hit;
   logic [31:0] w_rd_data;

   assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack;
   // Addresses below BASE_ADDR wrap to a huge offset and fall in the "other" range.
   assign w_off      = (wbs_adr_i - BASE_ADDR) >> 2;
   assign w_is_stat  = (w_off == NUM_WORDS);
   assign w_sel_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign w_ext_idx  = 32'(external_word_idx_i);
   assign w_ext_hit  = external_write_en_i && (w_ext_idx < NUM_WORDS);

   // Read mux sees the pre-update register values.
   always_comb begin
      w_rd_data = '0;
      if (w_is_stat) begin
         w_rd_data = 32'(r_fresh);
      end
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (w_off == k) begin
            w_rd_data = r_word[k];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            r_word[k] <= '0;
         end
         r_fresh <= '0;
         r_ack   <= 1'b0;
         r_dat   <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_ack <= w_req;
         if (w_req) begin
            r_dat <= wbs_we_i ? 32'h0 : w_rd_data;
         end
         r_irq <= |r_fresh;

         // Per word: the external deposit has priority over every bus effect,
         // both for the word contents and for the fresh flag.
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (w_ext_hit && (w_ext_idx == k)) begin
               if (ACCUMULATE != 0) begin
                  r_word[k] <= r_word[k] | external_spike_data_i;
               end else begin
                  r_word[k] <= external_spike_data_i;
               end
               r_fresh[k] <= 1'b1;
            end else if (w_req && (w_off == k)) begin
               if (wbs_we_i) begin
                  r_word[k] <= (r_word[k] & ~w_sel_mask) | (wbs_dat_i & w_sel_mask);
               end else begin
                  r_fresh[k] <= 1'b0;
                  if (CLEAR_ON_READ != 0) begin
                     r_word[k] <= '0;
                  end
               end
            end else if (w_req && wbs_we_i && w_is_stat &&
                         w_sel_mask[k] && wbs_dat_i[k]) begin
               r_fresh[k] <= 1'b0;
            end
         end
      end
   end

   assign wbs_ack_o       = r_ack;
   assign wbs_dat_o       = r_dat;
   assign spike_pending_o = r_fresh;
   assign spike_irq_o     = r_irq;

endmodule

// File: tb/tb_neuron_spike_out_bank.sv
// -----------------------------------------------------------------------------
// tb_neuron_spike_out_bank
//   Two instances share every input: u_dut_a uses the default build
//   (8 words, overwrite, no clear-on-read), u_dut_b uses 6 words with
//   OR-accumulate and clear-on-read. A transaction-level model keeps the
//   expected word contents and fresh mask of each instance.
// -----------------------------------------------------------------------------
module tb_neuron_spike_out_bank;

   localparam logic [31:0] BASE = 32'h3000_8000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic [31:0] edat;
   logic        een;
   logic [2:0]  eidx;

   logic        ack_a, ack_b, irq_a, irq_b;
   logic [31:0] dat_a, dat_b;
   logic [7:0]  pend_a;
   logic [5:0]  pend_b;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] m_word  [2][32];
   logic [31:0] m_fresh [2];

   always #5 clk = ~clk;

   neuron_spike_out_bank u_dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
      .external_spike_data_i(edat), .external_write_en_i(een),
      .external_word_idx_i(eidx), .spike_pending_o(pend_a), .spike_irq_o(irq_a)
   );

   neuron_spike_out_bank #(
      .NUM_WORDS(6), .IDX_W(3), .ACCUMULATE(1), .CLEAR_ON_READ(1)
   ) u_dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
      .external_spike_data_i(edat), .external_write_en_i(een),
      .external_word_idx_i(eidx), .spike_pending_o(pend_b), .spike_irq_o(irq_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_fresh[k] = '0;
         for (int i = 0; i < 32; i++) m_word[k][i] = '0;
      end
   endtask

   // Effect of one cycle of bus request plus optional external deposit.
   // Bus effects are applied first, the external deposit last so it wins.
   task automatic model_apply(input int k, input logic w_we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic e_en, input logic [2:0] e_idx,
                              input logic [31:0] e_dat, output logic [31:0] rd);
      logic [31:0] off, m, ev;
      int n;
      n   = (k == 1) ? 6 : 8;
      off = (a - BASE) >> 2;
      m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      ev  = (k == 1) ? (m_word[k][e_idx] | e_dat) : e_dat;
      rd  = '0;
      if (off < 32'(n)) begin
         if (w_we) begin
            m_word[k][off] = (m_word[k][off] & ~m) | (d & m);
         end else begin
            rd = m_word[k][off];
            m_fresh[k][off] = 1'b0;
            if (k == 1) m_word[k][off] = '0;
         end
      end else if (off == 32'(n)) begin
         if (w_we) m_fresh[k] = m_fresh[k] & ~(d & m);
         else      rd = m_fresh[k];
      end
      if (e_en && (int'(e_idx) < n)) begin
         m_word[k][e_idx]  = ev;
         m_fresh[k][e_idx] = 1'b1;
      end
   endtask

   task automatic chk_pend(input string tag);
      chk({tag, "_pend_a"}, {24'h0, pend_a}, m_fresh[0]);
      chk({tag, "_pend_b"}, {26'h0, pend_b}, m_fresh[1]);
   endtask

   task automatic chk_irq(input string tag);
      chk({tag, "_irq_a"}, {31'h0, irq_a}, {31'h0, |m_fresh[0]});
      chk({tag, "_irq_b"}, {31'h0, irq_b}, {31'h0, |m_fresh[1]});
   endtask

   function automatic logic [31:0] adr_of(input int off);
      return BASE + (32'(off) << 2);
   endfunction

   // One Wishbone transaction, optionally colliding with an external deposit.
   task automatic xfer(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                       input logic [3:0] t_sel, input logic t_een, input logic [2:0] t_eidx,
                       input logic [31:0] t_edat, output logic [31:0] got_a,
                       output logic [31:0] got_b);
      logic [31:0] ea, eb;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel;
      een = t_een; eidx = t_eidx; edat = t_edat;
      chk("ack_pre_a", {31'h0, ack_a}, 32'h0);
      chk("ack_pre_b", {31'h0, ack_b}, 32'h0);
      model_apply(0, t_we, t_adr, t_dat, t_sel, t_een, t_eidx, t_edat, ea);
      model_apply(1, t_we, t_adr, t_dat, t_sel, t_een, t_eidx, t_edat, eb);
      @(negedge clk);
      got_a = dat_a;
      got_b = dat_b;
      chk("ack_a", {31'h0, ack_a}, 32'h1);
      chk("ack_b", {31'h0, ack_b}, 32'h1);
      if (!t_we) begin
         chk("rd_a", dat_a, ea);
         chk("rd_b", dat_b, eb);
      end
      chk_pend("xfer");
      cyc = 1'b0; stb = 1'b0; we = 1'b0; een = 1'b0;
      @(negedge clk);
      chk("ack_post_a", {31'h0, ack_a}, 32'h0);
      chk("ack_post_b", {31'h0, ack_b}, 32'h0);
      if (!t_we) begin
         chk("hold_a", dat_a, ea);
         chk("hold_b", dat_b, eb);
      end
      chk_irq("xfer");
   endtask

   task automatic ext_only(input logic [2:0] t_idx, input logic [31:0] t_dat);
      logic [31:0] unused;
      @(negedge clk);
      een = 1'b1; eidx = t_idx; edat = t_dat;
      // An unrequested cycle: model it as a write to an unmapped offset.
      model_apply(0, 1'b1, adr_of(100), 32'h0, 4'h0, 1'b1, t_idx, t_dat, unused);
      model_apply(1, 1'b1, adr_of(100), 32'h0, 4'h0, 1'b1, t_idx, t_dat, unused);
      @(negedge clk);
      een = 1'b0;
      chk_pend("ext");
      @(negedge clk);
      chk_irq("ext");
   endtask

   logic [31:0] ga, gb;

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      adr = '0; wdat = '0; edat = '0; een = 1'b0; eidx = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_ack_a", {31'h0, ack_a}, 32'h0);
      chk("rst_dat_a", dat_a, 32'h0);
      chk("rst_dat_b", dat_b, 32'h0);
      chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
      chk_pend("rst");
      rst = 1'b0;

      // Reads after reset
      xfer(1'b0, adr_of(0), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t1_w0", ga, 32'h0);
      xfer(1'b0, adr_of(8), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t1_stat", ga, 32'h0);

      // Deposit then read back
      ext_only(3'd3, 32'hA5A5_0001);
      chk("t2_pend", {24'h0, pend_a}, 32'h08);
      chk("t2_irq", {31'h0, irq_a}, 32'h1);
      xfer(1'b0, adr_of(3), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t2_rd", ga, 32'hA5A5_0001);
      chk("t2_pend0", {24'h0, pend_a}, 32'h0);

      // Accumulate (instance b)
      ext_only(3'd1, 32'h0000_00F0);
      ext_only(3'd1, 32'h0000_000F);
      xfer(1'b0, adr_of(1), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t3_acc", gb, 32'h0000_00FF);
      chk("t3_ovw", ga, 32'h0000_000F);

      // Byte-lane write
      xfer(1'b1, adr_of(2), 32'hFFFF_FFFF, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      xfer(1'b1, adr_of(2), 32'h1122_3344, 4'b0101, 1'b0, 3'd0, 32'h0, ga, gb);
      xfer(1'b0, adr_of(2), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t4_sel_a", ga, 32'hFF22_FF44);
      chk("t4_sel_b", gb, 32'hFF22_FF44);

      // Collisions: external wins over WB write and over STATUS W1C
      xfer(1'b1, adr_of(0), 32'h2, 4'hF, 1'b1, 3'd0, 32'h1, ga, gb);
      chk("t5_fresh0", {31'h0, pend_a[0]}, 32'h1);
      xfer(1'b1, adr_of(8), 32'h1, 4'hF, 1'b1, 3'd0, 32'h1, ga, gb);
      chk("t5_w1c", {31'h0, pend_a[0]}, 32'h1);
      xfer(1'b0, adr_of(0), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t5_w0", ga, 32'h1);
      // External vs read of the same word: old value returned, flag ends set
      ext_only(3'd5, 32'h0000_1234);
      xfer(1'b0, adr_of(5), 32'h0, 4'hF, 1'b1, 3'd5, 32'h0000_5678, ga, gb);
      chk("t5_rdold", ga, 32'h0000_1234);
      chk("t5_rdfresh", {31'h0, pend_a[5]}, 32'h1);

      // Clear-on-read, unmapped read, out-of-range index (instance b)
      ext_only(3'd4, 32'hDEAD_BEEF);
      xfer(1'b0, adr_of(4), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t6_cor1", gb, 32'hDEAD_BEEF);
      xfer(1'b0, adr_of(4), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t6_cor2", gb, 32'h0);
      chk("t6_nocor", ga, 32'hDEAD_BEEF);
      xfer(1'b0, adr_of(11), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t6_unmapped", gb, 32'h0);
      ext_only(3'd7, 32'h0000_0077);
      xfer(1'b0, BASE - 32'd4, 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("t6_below", ga, 32'h0);

      // Held strobe: ack on alternating cycles
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = adr_of(8);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("held_ack", {31'h0, ack_a}, 32'((i % 2) == 0));
         chk("held_dat", dat_a, m_fresh[0]);
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);

      // Randomized traffic
      for (int it = 0; it < 250; it++) begin
         int r;
         logic [31:0] rd;
         r  = $urandom_range(0, 9);
         rd = ($urandom_range(0, 1) != 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
         if (r < 2) begin
            ext_only(3'($urandom_range(0, 7)), rd);
         end else begin
            xfer(1'($urandom_range(0, 1)), adr_of($urandom_range(0, 12)), $urandom,
                 4'($urandom_range(0, 15)), 1'(r < 6), 3'($urandom_range(0, 7)), rd,
                 ga, gb);
         end
      end

      // Reset in the middle of a request: no ack, everything cleared
      ext_only(3'd2, 32'h0000_00AA);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = adr_of(2);
      een = 1'b1; eidx = 3'd1; edat = 32'h5;
      rst = 1'b1;
      @(negedge clk);
      model_clear();
      chk("mrst_ack_a", {31'h0, ack_a}, 32'h0);
      chk("mrst_ack_b", {31'h0, ack_b}, 32'h0);
      chk("mrst_dat_a", dat_a, 32'h0);
      chk_pend("mrst");
      cyc = 1'b0; stb = 1'b0; een = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("mrst_ack2_a", {31'h0, ack_a}, 32'h0);
      chk_irq("mrst");
      xfer(1'b0, adr_of(2), 32'h0, 4'hF, 1'b0, 3'd0, 32'h0, ga, gb);
      chk("mrst_w2", ga, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
